// File: rtl/scratchstack_ctrl_pkg.sv
// Shared definitions for the scratch stack controller: command and FSM state
// encodings, grant identity and default geometry.
package scratchstack_ctrl_pkg;

  localparam int STACK_ADDR_W = 8;
  localparam int STACK_DATA_W = 32;
  localparam int STACK_DEPTH  = 2 ** STACK_ADDR_W;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_PUSH = 2'b01,
    CMD_POP  = 2'b10,
    CMD_PEEK = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD1,
    ST_RD2,
    ST_ACK
  } state_e;

  typedef enum logic {
    GNT_CORE = 1'b0,
    GNT_DBG  = 1'b1
  } grant_e;

endpackage

// File: rtl/scratchstack_mem.sv
// Single-port synchronous stack RAM, one-cycle registered read; a read during
// a write returns the old word. Written to map onto an ice40 block RAM.
module scratchstack_mem #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  // NOTE: the array and its read register carry no reset; a reset on a memory
  // prevents block-RAM inference and its contents are don't-care anyway.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/scratchstack_ctrl.sv
// Stack sequencer and two-port arbiter: owns the stack pointer, runs core
// PUSH/POP/PEEK and depth-indexed debug reads over a shared single-port RAM.
module scratchstack_ctrl
  import scratchstack_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = STACK_ADDR_W,
  parameter int DATA_WIDTH = STACK_DATA_W
) (
  input  logic                  CLK,
  input  logic                  resetn,
  input  logic                  core_req,
  input  logic [1:0]            core_cmd,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_ack,
  output logic                  core_err,
  output logic [DATA_WIDTH-1:0] core_rdata,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_depth,
  output logic                  dbg_ack,
  output logic                  dbg_err,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(2 ** ADDR_WIDTH);

  state_e                state_q, state_d;
  grant_e                gnt_q, gnt_d;
  logic                  err_q, err_d;
  logic                  pop_q, pop_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;

  logic                  mem_en, mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  core_sel, dbg_sel;
  cmd_e                  cmd;

  scratchstack_mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk_i  (CLK),
    .en_i   (mem_en),
    .we_i   (mem_we),
    .addr_i (addr_q),
    .wdata_i(core_wdata),
    .rdata_o(mem_rdata)
  );

  // gnt_q doubles as last_grant: on a tie the core wins unless it won last time.
  assign cmd      = cmd_e'(core_cmd);
  assign core_sel = core_req && (!dbg_req || gnt_q == GNT_DBG);
  assign dbg_sel  = dbg_req && !core_sel;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    err_d        = err_q;
    pop_d        = pop_q;
    addr_d       = addr_q;
    count_d      = count_q;
    core_rdata_d = core_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    mem_en       = 1'b0;
    mem_we       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (core_sel) begin
          gnt_d = GNT_CORE;
          err_d = 1'b0;
          pop_d = 1'b0;
          unique case (cmd)
            CMD_NOP: state_d = ST_ACK;
            CMD_PUSH: begin
              if (full_q) begin
                err_d        = 1'b1;
                core_rdata_d = '0;
                state_d      = ST_ACK;
              end else begin
                addr_d  = count_q[ADDR_WIDTH-1:0];
                state_d = ST_WR;
              end
            end
            CMD_POP, CMD_PEEK: begin
              if (empty_q) begin
                err_d        = 1'b1;
                core_rdata_d = '0;
                state_d      = ST_ACK;
              end else begin
                addr_d  = count_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
                pop_d   = (cmd == CMD_POP);
                state_d = ST_RD1;
              end
            end
            default: state_d = ST_ACK;
          endcase
        end else if (dbg_sel) begin
          gnt_d = GNT_DBG;
          err_d = 1'b0;
          pop_d = 1'b0;
          if ({1'b0, dbg_depth} >= count_q) begin
            err_d       = 1'b1;
            dbg_rdata_d = '0;
            state_d     = ST_ACK;
          end else begin
            addr_d  = count_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1) - dbg_depth;
            state_d = ST_RD1;
          end
        end
      end
      ST_WR: begin
        mem_en  = 1'b1;
        mem_we  = 1'b1;
        count_d = count_q + (ADDR_WIDTH+1)'(1);
        state_d = ST_ACK;
      end
      ST_RD1: begin
        mem_en  = 1'b1;
        state_d = ST_RD2;
      end
      ST_RD2: begin
        if (gnt_q == GNT_CORE) core_rdata_d = mem_rdata;
        else                   dbg_rdata_d  = mem_rdata;
        if (pop_q) count_d = count_q - (ADDR_WIDTH+1)'(1);
        state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_COUNT);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      gnt_q        <= GNT_DBG;
      err_q        <= 1'b0;
      pop_q        <= 1'b0;
      addr_q       <= '0;
      count_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      err_q        <= err_d;
      pop_q        <= pop_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      core_rdata_q <= core_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign core_ack   = (state_q == ST_ACK) && (gnt_q == GNT_CORE);
  assign dbg_ack    = (state_q == ST_ACK) && (gnt_q == GNT_DBG);
  assign core_err   = core_ack && err_q;
  assign dbg_err    = dbg_ack && err_q;
  assign core_rdata = core_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign count      = count_q;
  assign empty      = empty_q;
  assign full       = full_q;

endmodule
